// File: rtl/exu_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module  : exu_dispatch_if
//  Brief   : Decode / execute / writeback signal bundle for exu_dispatch.
//  Revision: 1.0  initial release
// ============================================================================
interface exu_dispatch_if #(
    parameter int XLEN        = 64,
    parameter int ALUOP_WIDTH = 4,
    parameter int BRSEL_WIDTH = 3
);
    // Decode side
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [XLEN-1:0]        in_rs1_val;
    logic [XLEN-1:0]        in_rs2_val;
    logic [XLEN-1:0]        in_imm;
    logic                   in_asel;
    logic                   in_bsel;
    logic [ALUOP_WIDTH-1:0] in_aluop;
    logic [BRSEL_WIDTH-1:0] in_brsel;
    logic [4:0]             in_rs1_idx;
    logic [4:0]             in_rs2_idx;
    logic [4:0]             in_rd;
    logic                   in_wen;
    // Execute side
    logic                   exu_valid;
    logic [XLEN-1:0]        exu_A;
    logic [XLEN-1:0]        exu_B;
    logic [XLEN-1:0]        exu_rs1;
    logic [XLEN-1:0]        exu_rs2;
    logic [XLEN-1:0]        exu_pc;
    logic [XLEN-1:0]        exu_sext;
    logic [ALUOP_WIDTH-1:0] exu_aluop;
    logic [BRSEL_WIDTH-1:0] exu_brsel;
    logic [XLEN-1:0]        exu_alu_out;
    logic [XLEN-1:0]        exu_br_out;
    logic                   exu_redirect;
    logic                   exu_finish;
    // Writeback / redirect side
    logic                   wb_valid;
    logic                   wb_wen;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;
    logic [XLEN-1:0]        wb_pc;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_pc;
    logic                   err;

    // Environment: decode, exu and writeback consumers
    modport master (
        output in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm, in_asel, in_bsel,
               in_aluop, in_brsel, in_rs1_idx, in_rs2_idx, in_rd, in_wen,
        input  in_ready,
        input  exu_valid, exu_A, exu_B, exu_rs1, exu_rs2, exu_pc, exu_sext,
               exu_aluop, exu_brsel,
        output exu_alu_out, exu_br_out, exu_redirect, exu_finish,
        input  wb_valid, wb_wen, wb_rd, wb_data, wb_pc, redirect_valid, redirect_pc, err
    );

    // Dispatcher
    modport slave (
        input  in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm, in_asel, in_bsel,
               in_aluop, in_brsel, in_rs1_idx, in_rs2_idx, in_rd, in_wen,
        output in_ready,
        output exu_valid, exu_A, exu_B, exu_rs1, exu_rs2, exu_pc, exu_sext,
               exu_aluop, exu_brsel,
        input  exu_alu_out, exu_br_out, exu_redirect, exu_finish,
        output wb_valid, wb_wen, wb_rd, wb_data, wb_pc, redirect_valid, redirect_pc, err
    );
endinterface
`default_nettype wire

// File: rtl/exu_dispatch.sv
`default_nettype none
// ============================================================================
//  Module  : exu_dispatch
//  Brief   : Single-op issue controller between decode and exu; issues one op,
//            waits for exu_finish (with timeout) and emits writeback/redirect.
//            Optional: EXU_DISPATCH_BYPASS_EN enables last-writeback bypass.
//  Revision: 1.0  initial release
// ============================================================================
module exu_dispatch #(
    parameter int XLEN        = 64,
    parameter int TIMEOUT     = 255,
    parameter int ALUOP_WIDTH = 4,
    parameter int BRSEL_WIDTH = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    exu_dispatch_if.slave     bus
);
    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_timer;
    logic                   r_exu_valid;
    logic [XLEN-1:0]        r_exu_a;
    logic [XLEN-1:0]        r_exu_b;
    logic [XLEN-1:0]        r_exu_rs1;
    logic [XLEN-1:0]        r_exu_rs2;
    logic [XLEN-1:0]        r_exu_pc;
    logic [XLEN-1:0]        r_exu_sext;
    logic [ALUOP_WIDTH-1:0] r_exu_aluop;
    logic [BRSEL_WIDTH-1:0] r_exu_brsel;
    logic [4:0]             r_rd;
    logic                   r_wen;
    logic                   r_wb_valid;
    logic                   r_wb_wen;
    logic [4:0]             r_wb_rd;
    logic [XLEN-1:0]        r_wb_data;
    logic [XLEN-1:0]        r_wb_pc;
    logic                   r_redirect_valid;
    logic [XLEN-1:0]        r_redirect_pc;
    logic                   r_err;

    logic                   w_finish;
    logic                   w_timeout;
    logic [7:0]             w_timer_nxt;
    logic [XLEN-1:0]        w_rs1;
    logic [XLEN-1:0]        w_rs2;

    assign w_timer_nxt = r_timer + 8'd1;
    // Finish has priority over an expiring timer on the same cycle
    assign w_finish    = (r_state == S_WAIT) && bus.exu_finish;
    assign w_timeout   = (r_state == S_WAIT) && !bus.exu_finish && (w_timer_nxt == c_timeout);

`ifdef EXU_DISPATCH_BYPASS_EN
    logic            r_byp_valid;
    logic [4:0]      r_byp_rd;
    logic [XLEN-1:0] r_byp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_valid <= 1'b0;
            r_byp_rd    <= 5'd0;
            r_byp_data  <= '0;
        end else if (w_finish && r_wen && (r_rd != 5'd0)) begin
            r_byp_valid <= 1'b1;
            r_byp_rd    <= r_rd;
            r_byp_data  <= bus.exu_alu_out;
        end else if (w_timeout) begin
            r_byp_valid <= 1'b0;
        end
    end

    assign w_rs1 = (r_byp_valid && (bus.in_rs1_idx != 5'd0) && (bus.in_rs1_idx == r_byp_rd))
                   ? r_byp_data : bus.in_rs1_val;
    assign w_rs2 = (r_byp_valid && (bus.in_rs2_idx != 5'd0) && (bus.in_rs2_idx == r_byp_rd))
                   ? r_byp_data : bus.in_rs2_val;
`else
    logic w_unused_idx;

    assign w_unused_idx = ^{bus.in_rs1_idx, bus.in_rs2_idx};
    assign w_rs1        = bus.in_rs1_val;
    assign w_rs2        = bus.in_rs2_val;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_timer          <= 8'd0;
            r_exu_valid      <= 1'b0;
            r_exu_a          <= '0;
            r_exu_b          <= '0;
            r_exu_rs1        <= '0;
            r_exu_rs2        <= '0;
            r_exu_pc         <= '0;
            r_exu_sext       <= '0;
            r_exu_aluop      <= '0;
            r_exu_brsel      <= '0;
            r_rd             <= 5'd0;
            r_wen            <= 1'b0;
            r_wb_valid       <= 1'b0;
            r_wb_wen         <= 1'b0;
            r_wb_rd          <= 5'd0;
            r_wb_data        <= '0;
            r_wb_pc          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_err            <= 1'b0;
        end else begin
            r_exu_valid      <= 1'b0;
            r_wb_valid       <= 1'b0;
            r_redirect_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_exu_valid <= 1'b1;
                        r_exu_a     <= bus.in_asel ? bus.in_pc  : w_rs1;
                        r_exu_b     <= bus.in_bsel ? bus.in_imm : w_rs2;
                        r_exu_rs1   <= w_rs1;
                        r_exu_rs2   <= w_rs2;
                        r_exu_pc    <= bus.in_pc;
                        r_exu_sext  <= bus.in_imm;
                        r_exu_aluop <= bus.in_aluop;
                        r_exu_brsel <= bus.in_brsel;
                        r_rd        <= bus.in_rd;
                        r_wen       <= bus.in_wen;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_finish) begin
                        r_wb_valid       <= 1'b1;
                        r_wb_wen         <= r_wen && (r_rd != 5'd0);
                        r_wb_rd          <= r_rd;
                        r_wb_data        <= bus.exu_alu_out;
                        r_wb_pc          <= r_exu_pc;
                        r_redirect_valid <= (r_exu_brsel != '0) && bus.exu_redirect;
                        r_redirect_pc    <= bus.exu_br_out;
                        r_state          <= S_WB;
                    end else if (w_timeout) begin
                        // Op is abandoned: no writeback, no redirect
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (r_state == S_IDLE);
    assign bus.exu_valid      = r_exu_valid;
    assign bus.exu_A          = r_exu_a;
    assign bus.exu_B          = r_exu_b;
    assign bus.exu_rs1        = r_exu_rs1;
    assign bus.exu_rs2        = r_exu_rs2;
    assign bus.exu_pc         = r_exu_pc;
    assign bus.exu_sext       = r_exu_sext;
    assign bus.exu_aluop      = r_exu_aluop;
    assign bus.exu_brsel      = r_exu_brsel;
    assign bus.wb_valid       = r_wb_valid;
    assign bus.wb_wen         = r_wb_wen;
    assign bus.wb_rd          = r_wb_rd;
    assign bus.wb_data        = r_wb_data;
    assign bus.wb_pc          = r_wb_pc;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.err            = r_err;
endmodule
`default_nettype wire

// File: tb/tb_exu_dispatch.sv
`default_nettype none
// ============================================================================
//  Module  : tb_exu_dispatch
//  Brief   : Directed self-checking bench for exu_dispatch (TIMEOUT = 8).
//  Revision: 1.0  initial release
// ============================================================================
module tb_exu_dispatch;
    localparam int XLEN = 64;
`ifdef EXU_DISPATCH_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    exu_dispatch_if #(.XLEN(XLEN), .ALUOP_WIDTH(4), .BRSEL_WIDTH(3)) bus ();

    exu_dispatch #(
        .XLEN(XLEN), .TIMEOUT(8), .ALUOP_WIDTH(4), .BRSEL_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] rs2,
                            input logic [63:0] imm, input logic asel, input logic bsel,
                            input logic [3:0] aluop, input logic [2:0] brsel,
                            input logic [4:0] i1, input logic [4:0] i2,
                            input logic [4:0] rd, input logic wen);
        bus.in_valid   = 1'b1;
        bus.in_pc      = pc;
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
        bus.in_imm     = imm;
        bus.in_asel    = asel;
        bus.in_bsel    = bsel;
        bus.in_aluop   = aluop;
        bus.in_brsel   = brsel;
        bus.in_rs1_idx = i1;
        bus.in_rs2_idx = i2;
        bus.in_rd      = rd;
        bus.in_wen     = wen;
    endtask

    // One-cycle exu_finish pulse; returns just after the edge that samples it
    task automatic exu_done(input logic [63:0] alu, input logic [63:0] br, input logic redir);
        bus.exu_alu_out  = alu;
        bus.exu_br_out   = br;
        bus.exu_redirect = redir;
        bus.exu_finish   = 1'b1;
        step();
        bus.exu_finish   = 1'b0;
        bus.exu_redirect = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        drive_op('0, '0, '0, '0, 1'b0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus.in_valid     = 1'b0;
        bus.exu_alu_out  = '0;
        bus.exu_br_out   = '0;
        bus.exu_redirect = 1'b0;
        bus.exu_finish   = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_exu_valid", 64'(bus.exu_valid), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_exu_A", bus.exu_A, 64'd0);

        // Plain ALU op, exu finishes one cycle after issue
        drive_op(64'h100, 64'd5, 64'd7, 64'h20, 1'b0, 1'b0, 4'd2, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("alu_exu_valid", 64'(bus.exu_valid), 64'd1);
        chk("alu_exu_A", bus.exu_A, 64'd5);
        chk("alu_exu_B", bus.exu_B, 64'd7);
        chk("alu_aluop", 64'(bus.exu_aluop), 64'd2);
        chk("alu_in_ready_issue", 64'(bus.in_ready), 64'd0);
        step();
        chk("alu_exu_valid_pulse", 64'(bus.exu_valid), 64'd0);
        exu_done(64'h1234, 64'hdead, 1'b1);
        chk("alu_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("alu_wb_rd", 64'(bus.wb_rd), 64'd3);
        chk("alu_wb_wen", 64'(bus.wb_wen), 64'd1);
        chk("alu_wb_data", bus.wb_data, 64'h1234);
        chk("alu_wb_pc", bus.wb_pc, 64'h100);
        chk("alu_no_redirect", 64'(bus.redirect_valid), 64'd0);
        step();
        chk("alu_wb_pulse", 64'(bus.wb_valid), 64'd0);
        chk("alu_back_idle", 64'(bus.in_ready), 64'd1);
        chk("alu_wb_data_hold", bus.wb_data, 64'h1234);
        chk("alu_exu_A_hold", bus.exu_A, 64'd5);

        // Taken branch, A=pc, B=imm, rd=0 suppresses wb_wen
        drive_op(64'h8000_0000, 64'd10, 64'd10, 64'h40, 1'b1, 1'b1, 4'd0, 3'd1, 5'd4, 5'd5, 5'd0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("br_exu_A", bus.exu_A, 64'h8000_0000);
        chk("br_exu_B", bus.exu_B, 64'h40);
        chk("br_exu_rs1", bus.exu_rs1, 64'd10);
        chk("br_exu_brsel", 64'(bus.exu_brsel), 64'd1);
        step();
        exu_done(64'h8000_0004, 64'h8000_0040, 1'b1);
        chk("br_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("br_redirect_valid", 64'(bus.redirect_valid), 64'd1);
        chk("br_redirect_pc", bus.redirect_pc, 64'h8000_0040);
        chk("br_rd0_wen", 64'(bus.wb_wen), 64'd0);
        step();
        chk("br_redirect_pulse", 64'(bus.redirect_valid), 64'd0);

        // in_valid held high: second op only accepted after returning to IDLE
        drive_op(64'h200, 64'h111, 64'h1, 64'h0, 1'b0, 1'b0, 4'd1, 3'd0, 5'd1, 5'd2, 5'd6, 1'b1);
        step();
        chk("hold_issue1", 64'(bus.exu_valid), 64'd1);
        drive_op(64'h204, 64'h222, 64'h2, 64'h0, 1'b0, 1'b0, 4'd1, 3'd0, 5'd1, 5'd2, 5'd7, 1'b1);
        step();
        chk("hold_no_reissue", 64'(bus.exu_valid), 64'd0);
        chk("hold_A_stable", bus.exu_A, 64'h111);
        chk("hold_not_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("hold_wait_no_issue", 64'(bus.exu_valid), 64'd0);
        exu_done(64'hAAA, 64'h0, 1'b0);
        chk("hold_wb1", 64'(bus.wb_valid), 64'd1);
        chk("hold_wb_not_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("hold_idle_ready", 64'(bus.in_ready), 64'd1);
        chk("hold_idle_no_issue", 64'(bus.exu_valid), 64'd0);
        step();
        bus.in_valid = 1'b0;
        chk("hold_issue2", 64'(bus.exu_valid), 64'd1);
        chk("hold_A_op2", bus.exu_A, 64'h222);
        step();
        exu_done(64'hBBB, 64'h0, 1'b0);
        chk("hold_wb2_data", bus.wb_data, 64'hBBB);
        chk("hold_wb2_rd", 64'(bus.wb_rd), 64'd7);
        step();

        // Timeout: exu never finishes
        drive_op(64'h300, 64'h1, 64'h2, 64'h0, 1'b0, 1'b0, 4'd3, 3'd1, 5'd1, 5'd2, 5'd5, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_still_waiting", 64'(bus.in_ready), 64'd0);
            chk("to_no_wb", 64'(bus.wb_valid), 64'd0);
        end
        step();
        chk("to_idle", 64'(bus.in_ready), 64'd1);
        chk("to_err", 64'(bus.err), 64'd1);
        chk("to_no_wb_abort", 64'(bus.wb_valid), 64'd0);
        exu_done(64'hBAD, 64'hBAD, 1'b1);
        chk("to_late_no_wb", 64'(bus.wb_valid), 64'd0);
        chk("to_late_no_redirect", 64'(bus.redirect_valid), 64'd0);
        chk("to_late_wb_data", bus.wb_data, 64'hBBB);
        chk("to_err_sticky", 64'(bus.err), 64'd1);

        // Reset while waiting
        drive_op(64'h400, 64'h5, 64'h6, 64'h0, 1'b0, 1'b0, 4'd1, 3'd0, 5'd1, 5'd2, 5'd8, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rw_err_clr", 64'(bus.err), 64'd0);
        chk("rw_exu_A", bus.exu_A, 64'd0);
        chk("rw_wb_data", bus.wb_data, 64'd0);
        chk("rw_redirect_pc", bus.redirect_pc, 64'd0);
        exu_done(64'h777, 64'h777, 1'b1);
        chk("rw_late_no_wb", 64'(bus.wb_valid), 64'd0);
        chk("rw_late_wb_data", bus.wb_data, 64'd0);

        // Bypass of last written-back value
        drive_op(64'h500, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 4'd0, 3'd0, 5'd1, 5'd2, 5'd4, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        exu_done(64'h99, 64'h0, 1'b0);
        chk("byp_wb_data", bus.wb_data, 64'h99);
        step();
        drive_op(64'h504, 64'h0, 64'h55, 64'h0, 1'b0, 1'b0, 4'd0, 3'd0, 5'd4, 5'd0, 5'd9, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("byp_exu_A", bus.exu_A, c_byp ? 64'h99 : 64'h0);
        chk("byp_exu_rs1", bus.exu_rs1, c_byp ? 64'h99 : 64'h0);
        chk("byp_exu_B_rs2_idx0", bus.exu_B, 64'h55);
        step();
        exu_done(64'h77, 64'h0, 1'b0);
        step();
        drive_op(64'h508, 64'h11, 64'h22, 64'h33, 1'b0, 1'b1, 4'd0, 3'd0, 5'd0, 5'd4, 5'd9, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("byp_idx0_A", bus.exu_A, 64'h11);
        chk("byp_B_imm", bus.exu_B, 64'h33);
        chk("byp_exu_rs2", bus.exu_rs2, c_byp ? 64'h99 : 64'h22);
        step();
        exu_done(64'h1, 64'h0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
